// File: rtl/lib_timer_ctrl.sv
// Programmable timer controller: prescaler plus max-value main counter behind a
// small register file, with one-shot/periodic modes and a pend/ack interrupt.
module lib_timer_ctrl #(
    parameter int DW = 16,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [1:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [1:0]    rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          irq_ack,
    output logic          irq,
    output logic          tick
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] period;
    logic [DW-1:0] cnt;
    logic [PW-1:0] presc;
    logic [PW-1:0] pc;
    logic          mode;
    logic          ien;
    logic          pend;

    logic          ctrl_wr;
    logic          go;
    logic          pt;
    logic          expiry;

    assign ctrl_wr = wr_en && (wr_addr == 2'd0);
    assign go      = wr_data[0];
    assign pt      = (pc >= presc);
    // >= rather than == so a PERIOD write below the live count still expires.
    assign expiry  = (state == RUN) && pt && (cnt >= period);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (ctrl_wr) begin
            state_nxt = go ? RUN : IDLE;
        end else if (expiry && !mode) begin
            state_nxt = DONE;
        end
    end

    always_comb begin
        irq     = pend & ien;
        rd_data = '0;
        case (rd_addr)
            2'd0:    rd_data = DW'({pend, state, ien, mode});
            2'd1:    rd_data = period;
            2'd2:    rd_data = DW'(presc);
            2'd3:    rd_data = cnt;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            period <= '0;
            presc  <= '0;
            mode   <= 1'b0;
            ien    <= 1'b0;
        end else if (wr_en) begin
            case (wr_addr)
                2'd0: begin
                    mode <= wr_data[1];
                    ien  <= wr_data[2];
                end
                2'd1:    period <= wr_data;
                2'd2:    presc  <= wr_data[PW-1:0];
                default: ;
            endcase
        end
    end

    // A CTRL write always wins over counting, even on the expiry cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc  <= '0;
            cnt <= '0;
        end else if (ctrl_wr || state != RUN) begin
            pc  <= '0;
            cnt <= '0;
        end else begin
            pc <= pt ? '0 : pc + PW'(1);
            if (pt) begin
                cnt <= (cnt >= period) ? '0 : cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick <= 1'b0;
            pend <= 1'b0;
        end else begin
            tick <= expiry;
            if (expiry) begin
                pend <= 1'b1;
            end else if (irq_ack) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lib_timer_ctrl.sv
// Self-checking bench for lib_timer_ctrl: an elapsed-cycle reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_lib_timer_ctrl;

    localparam int DW = 16;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_en;
    logic [1:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic [1:0]    rd_addr;
    logic [DW-1:0] rd_data;
    logic          irq_ack;
    logic          irq;
    logic          tick;

    int total = 0;
    int bad   = 0;
    bit armed = 0;

    lib_timer_ctrl #(.DW(DW), .PW(PW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .irq_ack (irq_ack),
        .irq     (irq),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    // Reference model: tracks cycles elapsed in the current interval; prescale
    // and main count are derived from it arithmetically (0=IDLE 1=RUN 2=DONE).
    int m_state, m_period, m_presc, m_e;
    bit m_mode, m_ien, m_pend, m_tick, m_exp;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_state <= 0; m_period <= 0; m_presc <= 0; m_e <= 0;
            m_mode <= 0; m_ien <= 0; m_pend <= 0; m_tick <= 0;
        end else begin
            m_exp = (m_state == 1) && ((m_e % (m_presc + 1)) == m_presc)
                    && ((m_e / (m_presc + 1)) >= m_period);
            m_tick <= m_exp;
            if (m_exp) m_pend <= 1;
            else if (irq_ack) m_pend <= 0;
            if (wr_en && wr_addr == 2'd1) m_period <= int'(wr_data);
            if (wr_en && wr_addr == 2'd2) m_presc <= int'(wr_data[PW-1:0]);
            if (wr_en && wr_addr == 2'd0) begin
                m_mode  <= wr_data[1];
                m_ien   <= wr_data[2];
                m_state <= wr_data[0] ? 1 : 0;
                m_e     <= 0;
            end else if (m_state == 1) begin
                if (m_exp) begin
                    m_e <= 0;
                    if (!m_mode) m_state <= 2;
                end else begin
                    m_e <= m_e + 1;
                end
            end
        end
    end

    function automatic int model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return 16 * int'(m_pend) + 4 * m_state + 2 * int'(m_ien) + int'(m_mode);
            2'd1:    return m_period;
            2'd2:    return m_presc;
            default: return (m_state == 1) ? m_e / (m_presc + 1) : 0;
        endcase
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check_output("model_irq", int'(irq), int'(m_pend & m_ien));
            check_output("model_tick", int'(tick), int'(m_tick));
            check_output("model_rd", int'(rd_data), model_rd(rd_addr));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [1:0] a, input int d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = DW'(d);
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic ack_pulse();
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output int v);
        rd_addr = a;
        #1;
        v = int'(rd_data);
    endtask

    task automatic count_ticks(input int n, output int c);
        c = 0;
        for (int k = 0; k < n; k++) begin
            step(1);
            if (tick) c++;
        end
    endtask

    task automatic wait_tick(output int edges);
        edges = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (tick) begin
                edges = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int v;
        int c;
        rstn = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; irq_ack = 1'b0;
        #2 rstn = 1'b0;
        #1 armed = 1;
        step(3);
        rstn = 1'b1;
        read_reg(2'd0, v); check_output("reset_status", v, 0);
        read_reg(2'd1, v); check_output("reset_period", v, 0);
        check_output("reset_irq", int'(irq), 0);

        $display("[TB] one-shot");
        apply_stimulus(2'd1, 3);
        apply_stimulus(2'd2, 1);
        apply_stimulus(2'd0, 5);
        wait_tick(c);
        check_output("oneshot_latency", c, 8);
        check_output("oneshot_irq", int'(irq), 1);
        read_reg(2'd0, v); check_output("oneshot_status", v, 26);
        read_reg(2'd3, v); check_output("oneshot_count", v, 0);
        count_ticks(50, c);
        check_output("oneshot_no_more_ticks", c, 0);

        $display("[TB] periodic");
        ack_pulse();
        apply_stimulus(2'd1, 4);
        apply_stimulus(2'd2, 0);
        apply_stimulus(2'd0, 7);
        count_ticks(50, c);
        check_output("periodic_ticks", c, 10);
        step(4);
        ack_pulse();
        check_output("ack_collide_tick", int'(tick), 1);
        read_reg(2'd0, v); check_output("ack_collide_status", v, 23);
        check_output("ack_collide_irq", int'(irq), 1);
        step(1);
        ack_pulse();
        check_output("ack_clears_irq", int'(irq), 0);
        apply_stimulus(2'd0, 0);
        read_reg(2'd0, v); check_output("stop_status", v, 0);

        $display("[TB] period shrink");
        apply_stimulus(2'd1, 100);
        apply_stimulus(2'd0, 7);
        step(50);
        read_reg(2'd3, v); check_output("shrink_count50", v, 50);
        apply_stimulus(2'd1, 10);
        check_output("shrink_no_tick_yet", int'(tick), 0);
        read_reg(2'd3, v); check_output("shrink_count51", v, 51);
        step(1);
        check_output("shrink_tick", int'(tick), 1);
        read_reg(2'd3, v); check_output("shrink_count0", v, 0);
        step(1);
        read_reg(2'd3, v); check_output("shrink_no_wrap", v, 1);
        read_reg(2'd0, v); check_output("shrink_status", v, 23);
        apply_stimulus(2'd0, 0);
        ack_pulse();

        $display("[TB] control collisions");
        apply_stimulus(2'd1, 4);
        apply_stimulus(2'd0, 7);
        step(2);
        read_reg(2'd3, v); check_output("restart_count2", v, 2);
        apply_stimulus(2'd0, 7);
        read_reg(2'd3, v); check_output("restart_count0", v, 0);
        wait_tick(c);
        check_output("restart_interval", c, 5);
        ack_pulse();
        step(3);
        read_reg(2'd0, v); check_output("pre_stop_status", v, 7);
        read_reg(2'd3, v); check_output("pre_stop_count", v, 4);
        apply_stimulus(2'd0, 0);
        check_output("stop_on_expiry_tick", int'(tick), 1);
        read_reg(2'd0, v); check_output("stop_on_expiry_status", v, 16);
        count_ticks(10, c);
        check_output("idle_no_ticks", c, 0);

        $display("[TB] every-cycle expiry");
        apply_stimulus(2'd1, 0);
        apply_stimulus(2'd2, 0);
        apply_stimulus(2'd0, 7);
        count_ticks(20, c);
        check_output("every_cycle_ticks", c, 20);
        apply_stimulus(2'd0, 3);
        check_output("mask_irq", int'(irq), 0);
        check_output("mask_tick", int'(tick), 1);
        read_reg(2'd0, v); check_output("mask_status", v, 21);

        $display("[TB] reset mid-run");
        step(2);
        rstn = 1'b0;
        #1;
        check_output("midreset_irq", int'(irq), 0);
        check_output("midreset_tick", int'(tick), 0);
        read_reg(2'd0, v); check_output("midreset_status", v, 0);
        read_reg(2'd3, v); check_output("midreset_count", v, 0);
        step(2);
        rstn = 1'b1;
        count_ticks(20, c);
        check_output("post_reset_no_ticks", c, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lib_timer_ctrl.md
Name: lib_timer_ctrl

Overview:
Programmable timer controller that sequences a prescaler and a max-value main counter from a small register interface. It supports one-shot and periodic modes and generates a level interrupt with a pending/acknowledge handshake. It sits next to the CPU memory-mapped I/O decode and serves as the system tick and timeout source.

Parameters:
DW, 16, width of the PERIOD register, the main counter and the read/write data buses
PW, 8, width of the PRESCALE register and the prescale counter (PW <= DW)

Ports:
clk  input  1  clock; everything is rising-edge
rstn  input  1  asynchronous active-low reset
wr_en  input  1  register write strobe, one write per cycle
wr_addr  input  2  write address: 0 CTRL, 1 PERIOD, 2 PRESCALE, 3 reserved (write ignored)
wr_data  input  DW  write data
rd_addr  input  2  read address: 0 STATUS, 1 PERIOD, 2 PRESCALE, 3 COUNT
rd_data  output  DW  combinational read data for rd_addr
irq_ack  input  1  single-cycle pulse that clears the pending interrupt
irq  output  1  interrupt, equal to pend & ien
tick  output  1  registered one-cycle pulse on every expiry event

Behaviour:
- Reset (asynchronous, rstn=0):
  - state=IDLE; period=0; presc=0; mode=0; ien=0; pend=0.
  - Prescale count pc=0 and main count cnt=0.
  - irq=0, tick=0, rd_data reflects the zeroed registers.
  - Reset mid-run aborts immediately. No expiry or tick is produced afterwards.
- CTRL write:
  - wr_data[0]=go, [1]=mode (1 periodic, 0 one-shot), [2]=ien.
  - mode and ien update on every CTRL write.
  - go=1 in any state: next state RUN, pc=0, cnt=0. This restarts the timer if it is already running.
  - go=0: next state IDLE, pc=0, cnt=0.
  - pend is never changed by a CTRL write.
- PERIOD/PRESCALE writes:
  - The new value takes effect the next cycle, including while in RUN.
  - Counters are not cleared by these writes.
- States:
  - IDLE: counters held at 0.
  - RUN: counting as described below.
  - DONE: one-shot has finished; counters held at 0; left only by a CTRL write.
- Counting in RUN, per cycle:
  - pt (prescale terminal) = (pc >= presc).
  - If pt, then pc<=0; otherwise pc<=pc+1.
  - On a cycle where pt is true:
    - If cnt >= period, this is an expiry: cnt<=0.
    - Otherwise cnt<=cnt+1.
  - Using >= guarantees expiry after a PERIOD write that drops below the current cnt. There is no wrap past period.
- Expiry interval:
  - The interval is (period+1)*(presc+1) cycles.
  - period=0 with presc=0 expires every cycle.
- On expiry:
  - tick=1 in the next cycle only.
  - pend<=1.
  - If mode=0, state<=DONE. If mode=1, stay in RUN.
- CTRL write in the same cycle as an expiry:
  - The write wins for state and counters.
  - The expiry still sets pend and pulses tick.
- Interrupt handshake:
  - irq_ack clears pend the next cycle.
  - If irq_ack and an expiry coincide, pend stays 1 (set wins).
  - irq_ack with pend=0 has no effect.
  - irq falls the cycle after ien is cleared, while pend is retained.
- Arithmetic:
  - cnt is DW bits and pc is PW bits, both unsigned.
  - Increments never overflow because the >= compares bound them.
  - A PRESCALE write uses wr_data[PW-1:0].
- rd_data:
  - STATUS = {zero-pad, pend, state[1:0], ien, mode}, with state encoded IDLE=0, RUN=1, DONE=2.
  - PERIOD and PRESCALE read zero-extended.
  - COUNT returns cnt.

Test Plan:
- Reset values: reset asserted mid-RUN -> irq=0, tick=0, STATUS=0, COUNT=0 immediately; no tick after reset is released.
- One-shot: PERIOD=3, PRESCALE=1, CTRL=0b101 -> tick exactly 8 cycles after RUN entry; irq=1; STATUS state=DONE; COUNT stays 0; no further ticks for 50 cycles.
- Periodic: PERIOD=4, PRESCALE=0, CTRL=0b111 -> tick every 5 cycles for 10 periods; an irq_ack coinciding with a tick leaves pend=1; an irq_ack 2 cycles later clears irq.
- PERIOD shrink: running with PERIOD=100 and COUNT=50, write PERIOD=10 -> expiry on the next tick and cnt=0, no wrap to 2^DW.
- Control collisions: CTRL go=1 written while cnt=2 in RUN -> COUNT=0 next cycle and the full interval restarts; CTRL go=0 written on the expiry cycle -> IDLE, with tick and pend still set.
- Edge: PERIOD=0, PRESCALE=0, periodic -> tick on every cycle; toggling ien=0 masks irq while STATUS pend remains 1.
